bridge_sequencer: RTL and testbench
===================================

BRIDGE_SEQUENCER -- requirements
Module: bridge_sequencer

Interface
REQ-001 Parameter WARN_CYCLES, default 16, is the number of cycles the alert runs before the car barrier closes.
REQ-002 Parameter CLEAR_TIMEOUT, default 64, is the maximum number of cycles to wait for the deck to empty with the barrier closed.
REQ-003 Parameter MOTOR_TIMEOUT, default 128, is the maximum number of cycles a bridge raise or lower may take.
REQ-004 Parameter HOLD_CYCLES, default 8, is the number of consecutive boat-free cycles required before lowering.
REQ-005 Parameter CNT_W, default 4, is the width of the car counter.
REQ-006 Timing parameters SHALL be in the range 1..255; the shared timer SHALL be 8 bits.
REQ-007 i_clk  in  1  clock; all logic on rising edge.
REQ-008 i_reset  in  1  synchronous, active-low reset.
REQ-009 i_boatClose  in  1  boat approaching.
REQ-010 i_boatHere  in  1  boat at the bridge.
REQ-011 i_carIn  in  1  car entered deck; each high cycle is one event.
REQ-012 i_carOut  in  1  car left deck; each high cycle is one event.
REQ-013 i_bridgeTop  in  1  upper limit switch.
REQ-014 i_bridgeBottom  in  1  lower limit switch.
REQ-015 o_carBarrier  out  1  barrier closed.
REQ-016 o_alert  out  1  warning lights/horn.
REQ-017 o_motorUp  out  1  raise-motor drive.
REQ-018 o_motorDown  out  1  lower-motor drive.
REQ-019 o_fault  out  1  sticky fault indicator.
REQ-020 o_state  out  3  current state encoding.
REQ-021 o_carCount  out  CNT_W  cars on deck.

Function
REQ-022 Define boat request as i_boatClose OR i_boatHere.
REQ-023 Car counter: +1 on i_carIn alone, -1 on i_carOut alone, unchanged when both or neither are high; it saturates at 2^CNT_W-1 and at 0.
REQ-024 The counter SHALL update in every state, including FAULT.
REQ-025 States: IDLE=000, WARN=001, BARRIER=010, RAISE=011, OPEN=100, LOWER=101, RELEASE=110, FAULT=111.
REQ-026 Outputs SHALL be decoded from the state register only (Moore), so they change one edge after the input that caused the transition.
REQ-027 Outputs {barrier, alert, up, down, fault} per state: IDLE 00000, WARN 01000, BARRIER 11000, RAISE 11100, OPEN 11000, LOWER 11010, RELEASE 10000, FAULT 11001.
REQ-028 IDLE: boat request -> WARN, timer loaded with WARN_CYCLES-1.
REQ-029 WARN: boat request low -> IDLE; otherwise timer==0 -> BARRIER; otherwise decrement the timer.
REQ-030 BARRIER: boat request low -> RELEASE; otherwise count==0 -> RAISE with timer loaded to MOTOR_TIMEOUT-1; otherwise timer expiry (loaded with CLEAR_TIMEOUT-1 on entry) -> FAULT.
REQ-031 RAISE: count!=0 -> FAULT; otherwise i_bridgeTop -> OPEN with timer loaded to HOLD_CYCLES-1; otherwise timer==0 -> FAULT.
REQ-032 OPEN: any boat request reloads HOLD_CYCLES-1; timer==0 with no boat request -> LOWER with timer loaded to MOTOR_TIMEOUT-1.
REQ-033 LOWER: boat request -> RAISE with timer reloaded to MOTOR_TIMEOUT-1; otherwise i_bridgeBottom -> RELEASE; otherwise timer==0 -> FAULT.
REQ-034 RELEASE: lasts exactly one cycle, then IDLE.
REQ-035 FAULT: absorbing; only reset exits it.
REQ-036 Both limit switches high at once in RAISE or LOWER -> FAULT.
REQ-037 o_motorUp and o_motorDown SHALL never be high in the same cycle.

Reset
REQ-038 While i_reset=0 at a clock edge: state=IDLE, timer=0, count=0; all 1-bit outputs=0; o_state=000; o_carCount=0.
REQ-039 Reset SHALL take priority over every transition and counter update, including mid-raise and in FAULT.

Verification
REQ-040 Nominal cycle: boatClose pulse, count=0, top after 5 cycles, boat clears, bottom after 5 cycles -> states 001(16 cycles), 010(1 cycle), 011, 100, 101, 110, 000 in order; o_fault stays 0.
REQ-041 Early abort: boat request drops after 3 WARN cycles -> IDLE next edge; barrier never asserts.
REQ-042 Deck not clear: count=2 entering BARRIER, no carOut -> FAULT after 64 cycles; o_fault=1 persists until reset.
REQ-043 Counter edges: 20 carIn pulses -> count saturates at 15; simultaneous carIn+carOut -> unchanged; carOut at 0 -> stays 0.
REQ-044 Re-raise: boat request returns during LOWER -> RAISE next edge; o_motorDown drops and o_motorUp rises in the same cycle.
REQ-045 Reset mid-RAISE -> next edge all outputs 0, o_state=000, o_carCount=0.

Source files
------------

// File: rtl/bridge_sequencer.sv
// Drawbridge sequencer: warns traffic, closes the barrier, confirms the deck is empty,
// raises the span for boats, lowers it again, and latches a fault on any motor or deck anomaly.
module bridge_sequencer #(
  parameter int WARN_CYCLES   = 16,
  parameter int CLEAR_TIMEOUT = 64,
  parameter int MOTOR_TIMEOUT = 128,
  parameter int HOLD_CYCLES   = 8,
  parameter int CNT_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_boatClose,
  input  logic             i_boatHere,
  input  logic             i_carIn,
  input  logic             i_carOut,
  input  logic             i_bridgeTop,
  input  logic             i_bridgeBottom,
  output logic             o_carBarrier,
  output logic             o_alert,
  output logic             o_motorUp,
  output logic             o_motorDown,
  output logic             o_fault,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_carCount
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_WARN    = 3'b001,
    S_BARRIER = 3'b010,
    S_RAISE   = 3'b011,
    S_OPEN    = 3'b100,
    S_LOWER   = 3'b101,
    S_RELEASE = 3'b110,
    S_FAULT   = 3'b111
  } state_t;

  localparam logic [7:0] WARN_LOAD  = 8'(WARN_CYCLES - 1);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_TIMEOUT - 1);
  localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  state_t           state_q;
  logic [7:0]       timer_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             boat_req;
  logic             both_limits;
  logic [4:0]       out_vec;

  assign boat_req    = i_boatClose | i_boatHere;
  assign both_limits = i_bridgeTop & i_bridgeBottom;

  // Deck occupancy: simultaneous in/out cancels; saturates at both ends.
  always_comb begin
    count_d = count_q;
    if (i_carIn && !i_carOut && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
    else if (i_carOut && !i_carIn && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  // One shared 8-bit timer, reloaded on every state entry that needs it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      case (state_q)
        S_IDLE: begin
          if (boat_req) begin
            state_q <= S_WARN;
            timer_q <= WARN_LOAD;
          end
        end
        S_WARN: begin
          if (!boat_req) state_q <= S_IDLE;
          else if (timer_q == 8'd0) begin
            state_q <= S_BARRIER;
            timer_q <= CLEAR_LOAD;
          end else timer_q <= timer_q - 8'd1;
        end
        S_BARRIER: begin
          if (!boat_req) state_q <= S_RELEASE;
          else if (count_q == '0) begin
            state_q <= S_RAISE;
            timer_q <= MOTOR_LOAD;
          end else if (timer_q == 8'd0) state_q <= S_FAULT;
          else timer_q <= timer_q - 8'd1;
        end
        S_RAISE: begin
          if (both_limits || (count_q != '0)) state_q <= S_FAULT;
          else if (i_bridgeTop) begin
            state_q <= S_OPEN;
            timer_q <= HOLD_LOAD;
          end else if (timer_q == 8'd0) state_q <= S_FAULT;
          else timer_q <= timer_q - 8'd1;
        end
        S_OPEN: begin
          if (boat_req) timer_q <= HOLD_LOAD;
          else if (timer_q == 8'd0) begin
            state_q <= S_LOWER;
            timer_q <= MOTOR_LOAD;
          end else timer_q <= timer_q - 8'd1;
        end
        S_LOWER: begin
          if (both_limits) state_q <= S_FAULT;
          else if (boat_req) begin
            state_q <= S_RAISE;
            timer_q <= MOTOR_LOAD;
          end else if (i_bridgeBottom) state_q <= S_RELEASE;
          else if (timer_q == 8'd0) state_q <= S_FAULT;
          else timer_q <= timer_q - 8'd1;
        end
        S_RELEASE: state_q <= S_IDLE;
        S_FAULT:   state_q <= S_FAULT;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode {barrier, alert, up, down, fault}; up and down never share a state.
  always_comb begin
    out_vec = 5'b00000;
    case (state_q)
      S_IDLE:    out_vec = 5'b00000;
      S_WARN:    out_vec = 5'b01000;
      S_BARRIER: out_vec = 5'b11000;
      S_RAISE:   out_vec = 5'b11100;
      S_OPEN:    out_vec = 5'b11000;
      S_LOWER:   out_vec = 5'b11010;
      S_RELEASE: out_vec = 5'b10000;
      S_FAULT:   out_vec = 5'b11001;
      default:   out_vec = 5'b00000;
    endcase
  end

  assign {o_carBarrier, o_alert, o_motorUp, o_motorDown, o_fault} = out_vec;
  assign o_state    = state_q;
  assign o_carCount = count_q;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed bench for bridge_sequencer with default parameters; each task
// drives one scenario and checks state, outputs and car count inline.
module tb_bridge_sequencer;

  logic       clk;
  logic       rst_n;
  logic       boat_close, boat_here, car_in, car_out, top, bottom;
  logic       barrier, alert, up, down, fault;
  logic [2:0] state;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  bridge_sequencer dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_boatClose(boat_close), .i_boatHere(boat_here),
    .i_carIn(car_in), .i_carOut(car_out),
    .i_bridgeTop(top), .i_bridgeBottom(bottom),
    .o_carBarrier(barrier), .o_alert(alert),
    .o_motorUp(up), .o_motorDown(down), .o_fault(fault),
    .o_state(state), .o_carCount(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns later, inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    boat_close = 0; boat_here = 0; car_in = 0; car_out = 0; top = 0; bottom = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // From IDLE with an empty deck: 1 edge to WARN, 16 in WARN, 1 in BARRIER.
  task automatic goto_raise(input string tag);
    boat_close = 1;
    repeat (18) tick();
    checks++;
    if (state !== 3'b011) begin
      errors++;
      $display("FAIL %s_reach_raise: state=%b expected=011", tag, state);
    end
  endtask

  task automatic test_reset();
    boat_close = 1; car_in = 1;
    rst_n = 0;
    tick();
    tick();
    checks++;
    if ({barrier, alert, up, down, fault, state, count} !== 12'b0) begin
      errors++;
      $display("FAIL reset_outputs: got=%b expected=%b",
               {barrier, alert, up, down, fault, state, count}, 12'b0);
    end
    rst_n = 1;
    idle_inputs();
    tick();
    checks++;
    if (state !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_hold: state=%b expected=000", state);
    end
  endtask

  task automatic test_nominal();
    int bad;
    bad = 0;
    boat_close = 1;
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b001_01000) begin
      errors++;
      $display("FAIL nominal_warn: got=%b expected=00101000", {state, barrier, alert, up, down, fault});
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (state !== 3'b001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nominal_warn_len: early_exits=%0d expected=0", bad);
    end
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b010_11000) begin
      errors++;
      $display("FAIL nominal_barrier: got=%b expected=01011000", {state, barrier, alert, up, down, fault});
    end
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b011_11100) begin
      errors++;
      $display("FAIL nominal_raise: got=%b expected=01111100", {state, barrier, alert, up, down, fault});
    end
    repeat (4) tick();
    top = 1;
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b100_11000) begin
      errors++;
      $display("FAIL nominal_open: got=%b expected=10011000", {state, barrier, alert, up, down, fault});
    end
    top = 0; boat_close = 0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (state !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nominal_hold_len: early_exits=%0d expected=0", bad);
    end
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b101_11010) begin
      errors++;
      $display("FAIL nominal_lower: got=%b expected=10111010", {state, barrier, alert, up, down, fault});
    end
    repeat (4) tick();
    bottom = 1;
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b110_10000) begin
      errors++;
      $display("FAIL nominal_release: got=%b expected=11010000", {state, barrier, alert, up, down, fault});
    end
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b000_00000) begin
      errors++;
      $display("FAIL nominal_idle: got=%b expected=00000000", {state, barrier, alert, up, down, fault});
    end
    bottom = 0;
  endtask

  task automatic test_abort();
    int barrier_seen;
    barrier_seen = 0;
    boat_here = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (barrier !== 1'b0) barrier_seen++;
    end
    checks++;
    if (state !== 3'b001) begin
      errors++;
      $display("FAIL abort_in_warn: state=%b expected=001", state);
    end
    boat_here = 0;
    tick();
    if (barrier !== 1'b0) barrier_seen++;
    checks++;
    if (state !== 3'b000 || barrier_seen != 0) begin
      errors++;
      $display("FAIL abort_idle: state=%b barrier_cycles=%0d expected=000/0", state, barrier_seen);
    end
  endtask

  task automatic test_deck_fault();
    int bad;
    bad = 0;
    car_in = 1;
    repeat (2) tick();
    car_in = 0;
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL deck_count: count=%0d expected=2", count);
    end
    boat_close = 1;
    repeat (17) tick();
    checks++;
    if (state !== 3'b010) begin
      errors++;
      $display("FAIL deck_barrier: state=%b expected=010", state);
    end
    for (int i = 0; i < 63; i++) begin
      tick();
      if (state !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL deck_wait_len: early_exits=%0d expected=0", bad);
    end
    tick();
    checks++;
    if ({state, barrier, alert, up, down, fault} !== 8'b111_11001) begin
      errors++;
      $display("FAIL deck_fault: got=%b expected=11111001", {state, barrier, alert, up, down, fault});
    end
    boat_close = 0; bottom = 1;
    repeat (5) tick();
    car_out = 1;
    tick();
    car_out = 0; bottom = 0;
    checks++;
    if (state !== 3'b111 || fault !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL fault_sticky: state=%b fault=%b count=%0d expected=111/1/1", state, fault, count);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || state !== 3'b000) begin
      errors++;
      $display("FAIL fault_cleared: state=%b fault=%b expected=000/0", state, fault);
    end
  endtask

  task automatic test_counter();
    car_in = 1;
    repeat (20) tick();
    checks++;
    if (count !== 4'd15) begin
      errors++;
      $display("FAIL count_saturate_hi: count=%0d expected=15", count);
    end
    car_out = 1;
    repeat (3) tick();
    checks++;
    if (count !== 4'd15) begin
      errors++;
      $display("FAIL count_both: count=%0d expected=15", count);
    end
    car_in = 0;
    repeat (5) tick();
    checks++;
    if (count !== 4'd10) begin
      errors++;
      $display("FAIL count_decrement: count=%0d expected=10", count);
    end
    repeat (12) tick();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL count_saturate_lo: count=%0d expected=0", count);
    end
    car_out = 0;
    checks++;
    if (state !== 3'b000) begin
      errors++;
      $display("FAIL count_no_move: state=%b expected=000", state);
    end
  endtask

  task automatic test_reraise();
    goto_raise("reraise");
    top = 1;
    tick();
    top = 0; boat_close = 0;
    repeat (8) tick();
    repeat (2) tick();
    checks++;
    if ({state, up, down} !== 5'b101_01) begin
      errors++;
      $display("FAIL reraise_lower: got=%b expected=10101", {state, up, down});
    end
    boat_here = 1;
    tick();
    checks++;
    if ({state, up, down} !== 5'b011_10) begin
      errors++;
      $display("FAIL reraise_raise: got=%b expected=01110", {state, up, down});
    end
    // Reset lands mid-raise while a car event is also present.
    car_in = 1;
    rst_n = 0;
    tick();
    checks++;
    if ({barrier, alert, up, down, fault, state, count} !== 12'b0) begin
      errors++;
      $display("FAIL reset_mid_raise: got=%b expected=%b",
               {barrier, alert, up, down, fault, state, count}, 12'b0);
    end
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_limit_faults();
    goto_raise("both");
    top = 1; bottom = 1;
    tick();
    checks++;
    if (state !== 3'b111 || up !== 1'b0) begin
      errors++;
      $display("FAIL both_limits_fault: state=%b up=%b expected=111/0", state, up);
    end
    do_reset();
    goto_raise("car");
    car_in = 1;
    tick();
    car_in = 0;
    tick();
    checks++;
    if (state !== 3'b111) begin
      errors++;
      $display("FAIL car_in_raise_fault: state=%b expected=111", state);
    end
    do_reset();
    goto_raise("timeout");
    repeat (127) tick();
    checks++;
    if (state !== 3'b011) begin
      errors++;
      $display("FAIL raise_timeout_early: state=%b expected=011", state);
    end
    tick();
    checks++;
    if (state !== 3'b111) begin
      errors++;
      $display("FAIL raise_timeout: state=%b expected=111", state);
    end
    do_reset();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_nominal();
    test_abort();
    test_deck_fault();
    test_counter();
    test_reraise();
    test_limit_faults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
